// File: rtl/wb_servo_ramp.sv
`default_nettype none
// ============================================================================
// wb_servo_ramp : Wishbone-mapped 8-channel servo pulse generator with
//                 per-frame position ramping and a motion-done interrupt.
// Revision      : 1.0
// ============================================================================
module wb_servo_ramp #(
  parameter int clk_freq = 100000000,
  parameter int frame_us = 20000,
  parameter int pos_min  = 500,
  parameter int pos_max  = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [7:0]  servo_o,
  output logic        intr
);

  localparam int          DIV_RAW    = clk_freq / 1000000;
  localparam int          DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [15:0] FRAME_LAST = 16'(frame_us - 1);
  localparam logic [15:0] POS_MIN    = 16'(pos_min);
  localparam logic [15:0] POS_MAX    = 16'(pos_max);
  localparam logic [15:0] POS_RESET  = 16'd1500;

  logic        enable, irq_en, done;
  logic [7:0]  step;
  logic [15:0] target   [8];
  logic [15:0] pos      [8];
  logic [15:0] next_pos [8];
  logic [15:0] presc, fc;
  logic [7:0]  busy, busy_next;
  logic [15:0] wr_merged, wr_target;
  logic [31:0] rdata;
  logic [3:0]  reg_idx;
  logic        access, wr, tick, boundary, done_set, done_clr;
  logic        unused;

  assign reg_idx  = wb_adr_i[5:2];
  assign access   = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr       = access & wb_we_i;
  assign tick     = enable && (presc == DIV_LAST);
  assign boundary = tick && (fc == FRAME_LAST);
  assign done_set = boundary && (|busy) && !(|busy_next);
  assign done_clr = wr && (reg_idx == 4'd1) && wb_sel_i[1] && wb_dat_i[8];
  assign intr     = done & irq_en;
  assign unused   = &{1'b0, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

  // Byte-lane merge with the current target, then clamp into the legal pulse range.
  always_comb begin
    wr_merged = target[reg_idx[2:0]];
    if (wb_sel_i[0]) wr_merged[7:0]  = wb_dat_i[7:0];
    if (wb_sel_i[1]) wr_merged[15:8] = wb_dat_i[15:8];
    if (wr_merged < POS_MIN)      wr_target = POS_MIN;
    else if (wr_merged > POS_MAX) wr_target = POS_MAX;
    else                          wr_target = wr_merged;
  end

  // Ramp one step toward the target; a remaining distance within one step lands exactly on it.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      next_pos[n] = target[n];
      if (step != 8'd0) begin
        if ((pos[n] < target[n]) && ((target[n] - pos[n]) > {8'd0, step}))
          next_pos[n] = pos[n] + {8'd0, step};
        else if ((pos[n] > target[n]) && ((pos[n] - target[n]) > {8'd0, step}))
          next_pos[n] = pos[n] - {8'd0, step};
      end
      busy[n]      = (pos[n] != target[n]);
      busy_next[n] = (next_pos[n] != target[n]);
    end
  end

  always_comb begin
    rdata = '0;
    if (reg_idx[3]) begin
      rdata = {pos[reg_idx[2:0]], target[reg_idx[2:0]]};
    end else begin
      case (reg_idx[2:0])
        3'd0:    rdata = {30'd0, irq_en, enable};
        3'd1:    rdata = {23'd0, done, busy};
        3'd2:    rdata = {24'd0, step};
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      step     <= 8'd0;
      done     <= 1'b0;
      presc    <= 16'd0;
      fc       <= 16'd0;
      servo_o  <= 8'd0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      for (int n = 0; n < 8; n++) begin
        target[n] <= POS_RESET;
        pos[n]    <= POS_RESET;
      end
    end else begin
      wb_ack_o <= access;
      if (access) wb_dat_o <= rdata;

      if (!enable) begin
        presc <= 16'd0;
        fc    <= 16'd0;
      end else if (tick) begin
        presc <= 16'd0;
        fc    <= (fc == FRAME_LAST) ? 16'd0 : fc + 16'd1;
      end else begin
        presc <= presc + 16'd1;
      end

      for (int n = 0; n < 8; n++) begin
        servo_o[n] <= enable && (fc < pos[n]);
        if (boundary) pos[n] <= next_pos[n];
      end

      done <= done_set | (done & ~done_clr);

      if (wr) begin
        if (reg_idx[3]) begin
          target[reg_idx[2:0]] <= wr_target;
        end else if ((reg_idx == 4'd0) && wb_sel_i[0]) begin
          enable <= wb_dat_i[0];
          irq_en <= wb_dat_i[1];
        end else if ((reg_idx == 4'd2) && wb_sel_i[0]) begin
          step <= wb_dat_i[7:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_servo_ramp.md
WB_SERVO_RAMP -- requirements
Module: wb_servo_ramp

Interface
REQ-001 SHALL have parameter clk_freq, default 100000000: system clock in Hz; divisor = clk_freq/1000000 (integer ≥1) gives a 1 µs tick.
REQ-002 SHALL have parameter frame_us, default 20000: servo frame period in µs.
REQ-003 SHALL have parameter pos_min, default 500: minimum pulse width in µs.
REQ-004 SHALL have parameter pos_max, default 2500: maximum pulse width in µs.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port wb_adr_i, input, 32: Wishbone address; only bits [5:2] are decoded.
REQ-008 SHALL have port wb_dat_i, input, 32: Wishbone write data.
REQ-009 SHALL have port wb_dat_o, output, 32: Wishbone read data.
REQ-010 SHALL have ports wb_stb_i, wb_cyc_i and wb_we_i, input, 1 each: Wishbone strobe, cycle and write enable.
REQ-011 SHALL have port wb_sel_i, input, 4: byte-lane enables; write lanes with sel=0 are left unchanged.
REQ-012 SHALL have port wb_ack_o, output, 1: Wishbone acknowledge.
REQ-013 SHALL have port servo_o, output, 8: registered servo pulse outputs, channels 0..7.
REQ-014 SHALL have port intr, output, 1: active-high, level "motion done" interrupt.

Function
REQ-015 SHALL decode the register map on adr[5:2]:
- 0x00 CTRL: bit0 enable, bit1 irq_en.
- 0x04 STATUS: read returns [7:0] busy per channel and bit8 done; writing 1 to bit8 clears done.
- 0x08 STEP: [7:0], ramp step in µs per frame.
- 0x0C: reads 0, writes ignored.
- 0x20+4*n TARGET[n]: write [15:0] sets the target; read returns {pos[n][15:0], target[n][15:0]}.
- Any other address: reads 0, writes ignored.
REQ-016 SHALL assert wb_ack_o for exactly one cycle, in the cycle after stb&cyc while ack is low; back-to-back accesses therefore take 2 cycles each.
REQ-017 SHALL register wb_dat_o and hold it valid during the ack cycle.
REQ-018 SHALL perform a write in the ack cycle.
REQ-019 SHALL clamp a written target outside [pos_min, pos_max] to the nearest bound.
REQ-020 SHALL set busy[n] when pos[n] ≠ target[n].
REQ-021 SHALL generate the µs tick from a prescaler that counts 0..divisor-1 and pulses on wrap.
REQ-022 SHALL keep a frame counter fc that counts 0..frame_us-1 on ticks and wraps to 0; the wrap is the frame boundary.
REQ-023 SHALL drive servo_o[n] high when enable=1 and fc < pos[n], and low otherwise.
REQ-024 SHALL update positions only at a frame boundary:
- STEP=0: pos jumps to target.
- pos < target: pos = min(pos+STEP, target).
- pos > target: pos = max(pos-STEP, target).
REQ-025 SHALL NOT alter the pulse currently being output when a target is written mid-frame; the new target takes effect at the next frame boundary.
REQ-026 SHALL, while enable=0, hold the prescaler and fc at 0, freeze pos, force servo_o to 0, and keep Wishbone access functional.
REQ-027 SHALL restart from fc=0, prescaler=0 on an enable 0→1 transition, with servo_o going high on the next cycle for channels with pos>0.
REQ-028 SHALL set done at a frame boundary where the busy vector goes from nonzero to all-zero.
REQ-029 SHALL give the set of done priority over a simultaneous write-1-clear.
REQ-030 SHALL drive intr = done & irq_en.
REQ-031 SHALL cap the STEP arithmetic at the target with no overflow/underflow; 16-bit arithmetic is sufficient.

Reset
REQ-032 SHALL, while rst=0 (asynchronous), set:
- enable=0, irq_en=0, STEP=0, done=0;
- all target and pos = 1500;
- prescaler=0, fc=0;
- servo_o=0, wb_ack_o=0, wb_dat_o=0, intr=0.
REQ-033 SHALL abort any Wishbone transfer in progress on reset, with no ack issued.
REQ-034 SHALL resume operation on the first rising clk edge after rst deasserts.

Verification
All scenarios use clk_freq=1000000 (1 cycle/µs) and frame_us=3000.
REQ-035 Reset: rst low mid-frame with enable=1 → servo_o=0 immediately; after release, all TARGET reads return 0x05DC05DC.
REQ-036 Pulse width: CTRL=1 → every channel high for exactly 1500 cycles, then low; period 3000 cycles.
REQ-037 Clamp/jump: STEP=0, write TARGET[3]=3000 → TARGET[3] read returns target 2500; after the next boundary channel 3 pulse = 2500 cycles.
REQ-038 Ramp: STEP=100, TARGET[0]=1800 → pulse widths 1600, 1700, 1800 over successive frames; busy[0] clears; done=1; intr=1 when irq_en=1; write STATUS bit8=1 → intr=0.
REQ-039 Mid-frame write: TARGET[1]=1000 written at fc=500 with STEP=0 → the current pulse is still 1500, the next pulse is 1000.
REQ-040 Bus: sel=4'b0011 write of 0x12345678 to STEP → STEP=0x78; out-of-map read returns 0; every access acks in exactly 1 cycle.
